// File: rtl/umul_bi_ctrl.sv
// rtl/umul_bi_ctrl.sv - sequencer for one bipolar unary multiplier lane
//
// Purpose: accepts a multiply request (valid/ready), clears the lane's Sobol
// generators, strobes the B-operand load, enables the lane for 2^BITWIDTH
// cycles while counting ones on the product stream, then holds the result
// with a valid/ready handshake.
//
// Optional feature macro: UMUL_CTRL_BIPOLAR_OUT_EN
//   defined   -> oRes = 2*ones - 2^BITWIDTH (two's complement)
//   undefined -> oRes = ones count, zero-extended
//
// Ports:
//   iClk, iRst           clock, asynchronous active-high reset
//   iReqValid/oReqReady  request handshake (ready only in IDLE)
//   iAbort               cancel an operation in CLR/LOAD/RUN
//   iMult                product bit returned by the lane
//   oClr, oLoadB, oEn    lane control pins
//   oBusy                high in every state except IDLE
//   oResValid/iResReady  result handshake
//   oRes                 result, BITWIDTH+2 bits
module umul_bi_ctrl #(
  parameter int BITWIDTH = 8
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic                iReqValid,
  output logic                oReqReady,
  input  logic                iAbort,
  input  logic                iMult,
  output logic                oClr,
  output logic                oLoadB,
  output logic                oEn,
  output logic                oBusy,
  output logic                oResValid,
  input  logic                iResReady,
  output logic [BITWIDTH+1:0] oRes
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CLR  = 3'd1,
    LOAD = 3'd2,
    RUN  = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [BITWIDTH-1:0] CNT_LAST = '1;
  localparam logic [BITWIDTH-1:0] CNT_ONE  = {{(BITWIDTH-1){1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [BITWIDTH-1:0] cnt_q, cnt_d;
  logic [BITWIDTH:0]   acc_q, acc_d;
  logic [BITWIDTH:0]   acc_next;
  logic [BITWIDTH+1:0] res_q, res_d;
  logic [BITWIDTH+1:0] res_enc;

  logic req_ready_q, req_ready_d;
  logic clr_q, clr_d;
  logic load_b_q, load_b_d;
  logic en_q, en_d;
  logic busy_q, busy_d;
  logic res_valid_q, res_valid_d;

  // Ones count including the current RUN cycle's product bit, so the last
  // RUN cycle's sample lands in the result captured on entry to DONE.
  assign acc_next = acc_q + {{BITWIDTH{1'b0}}, iMult};

`ifdef UMUL_CTRL_BIPOLAR_OUT_EN
  localparam logic [BITWIDTH+1:0] FULL_SCALE = {2'b01, {BITWIDTH{1'b0}}};
  assign res_enc = {acc_next, 1'b0} - FULL_SCALE;
`else
  assign res_enc = {1'b0, acc_next};
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    res_d   = res_q;

    case (state_q)
      IDLE: begin
        // iAbort is deliberately ignored here.
        if (iReqValid && req_ready_q) state_d = CLR;
      end
      CLR: begin
        cnt_d   = '0;
        acc_d   = '0;
        state_d = iAbort ? IDLE : LOAD;
      end
      LOAD: begin
        // B buffer is not valid yet, so this cycle's iMult is not counted.
        state_d = iAbort ? IDLE : RUN;
      end
      RUN: begin
        if (iAbort) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
          acc_d = acc_next;
          if (cnt_q == CNT_LAST) begin
            state_d = DONE;
            res_d   = res_enc;
          end
        end
      end
      DONE: begin
        if (iResReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are decoded from the next state.
    req_ready_d = (state_d == IDLE);
    clr_d       = (state_d == CLR);
    load_b_d    = (state_d == LOAD);
    en_d        = (state_d == LOAD) || (state_d == RUN);
    busy_d      = (state_d != IDLE);
    res_valid_d = (state_d == DONE);
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      res_q       <= '0;
      req_ready_q <= 1'b1;
      clr_q       <= 1'b0;
      load_b_q    <= 1'b0;
      en_q        <= 1'b0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      res_q       <= res_d;
      req_ready_q <= req_ready_d;
      clr_q       <= clr_d;
      load_b_q    <= load_b_d;
      en_q        <= en_d;
      busy_q      <= busy_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign oReqReady = req_ready_q;
  assign oClr      = clr_q;
  assign oLoadB    = load_b_q;
  assign oEn       = en_q;
  assign oBusy     = busy_q;
  assign oResValid = res_valid_q;
  assign oRes      = res_q;

endmodule

// File: tb/tb_umul_bi_ctrl.sv
// tb/tb_umul_bi_ctrl.sv - directed self-checking bench for umul_bi_ctrl
module tb_umul_bi_ctrl;

  logic       iClk = 1'b0;
  logic       iRst = 1'b1;
  logic       iReqValid = 1'b0;
  logic       oReqReady;
  logic       iAbort = 1'b0;
  logic       iMult = 1'b0;
  logic       oClr;
  logic       oLoadB;
  logic       oEn;
  logic       oBusy;
  logic       oResValid;
  logic       iResReady = 1'b0;
  logic [5:0] oRes;

  int nvec = 0;
  int nerr = 0;

  umul_bi_ctrl #(.BITWIDTH(4)) dut (
    .iClk(iClk), .iRst(iRst),
    .iReqValid(iReqValid), .oReqReady(oReqReady),
    .iAbort(iAbort), .iMult(iMult),
    .oClr(oClr), .oLoadB(oLoadB), .oEn(oEn), .oBusy(oBusy),
    .oResValid(oResValid), .iResReady(iResReady), .oRes(oRes)
  );

  always #5 iClk = ~iClk;

  function automatic logic [5:0] exp_res(input int ones);
`ifdef UMUL_CTRL_BIPOLAR_OUT_EN
    return 6'(2 * ones - 16);
`else
    return 6'(ones);
`endif
  endfunction

  // Issues one request and tracks it cycle by cycle (cycle 1 = first cycle
  // after the accepting edge) until oResValid is seen or 40 cycles pass.
  // mode 0: iMult=0, mode 1: iMult=1, mode 2: 1,0,... from cycle 3.
  task automatic op(input int mode, output logic [5:0] res, output int vcyc,
                    output int clr_c, output int load_c,
                    output int en_first, output int en_last);
    vcyc = -1; clr_c = -1; load_c = -1; en_first = -1; en_last = -1;
    res = '0;
    @(negedge iClk);
    iReqValid = 1'b1;
    iMult = (mode == 1);
    for (int c = 1; c <= 40 && vcyc < 0; c++) begin
      @(negedge iClk);
      iReqValid = 1'b0;
      if (mode == 1)      iMult = 1'b1;
      else if (mode == 2) iMult = (c >= 3) && (((c - 3) % 2) == 0);
      else                iMult = 1'b0;
      if (oClr && clr_c < 0) clr_c = c;
      if (oLoadB && load_c < 0) load_c = c;
      if (oEn) begin
        if (en_first < 0) en_first = c;
        en_last = c;
      end
      if (oResValid) begin
        vcyc = c;
        res = oRes;
      end
    end
    iMult = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge iClk);
    nvec++;
    if ({oReqReady, oClr, oLoadB, oEn, oBusy, oResValid} !== 6'b100000 || oRes !== 6'd0) begin
      nerr++;
      $display("FAIL reset_outputs: got rdy/clr/ld/en/busy/vld=%b res=%0d, need 100000 res=0",
               {oReqReady, oClr, oLoadB, oEn, oBusy, oResValid}, oRes);
    end
    iRst = 1'b0;
    @(negedge iClk);
  endtask

  task automatic test_ones;
    logic [5:0] res;
    int vcyc, clr_c, load_c, en_first, en_last;
    op(1, res, vcyc, clr_c, load_c, en_first, en_last);
    nvec++;
    if (clr_c !== 1) begin nerr++; $display("FAIL ones_clr_cycle: got %0d need 1", clr_c); end
    nvec++;
    if (load_c !== 2) begin nerr++; $display("FAIL ones_load_cycle: got %0d need 2", load_c); end
    nvec++;
    if (en_first !== 2 || en_last !== 18) begin
      nerr++; $display("FAIL ones_en_window: got %0d..%0d need 2..18", en_first, en_last);
    end
    nvec++;
    if (vcyc !== 19) begin nerr++; $display("FAIL ones_valid_cycle: got %0d need 19", vcyc); end
    nvec++;
    if (res !== exp_res(16)) begin
      nerr++; $display("FAIL ones_result: got %b need %b", res, exp_res(16));
    end
    iResReady = 1'b1;
    @(negedge iClk);
    iResReady = 1'b0;
    nvec++;
    if (oReqReady !== 1'b1 || oResValid !== 1'b0 || oBusy !== 1'b0) begin
      nerr++;
      $display("FAIL ones_handshake_idle: got rdy=%b vld=%b busy=%b need 1 0 0",
               oReqReady, oResValid, oBusy);
    end
  endtask

  task automatic test_zeros;
    logic [5:0] res;
    int vcyc, clr_c, load_c, en_first, en_last;
    op(0, res, vcyc, clr_c, load_c, en_first, en_last);
    nvec++;
    if (vcyc !== 19 || res !== exp_res(0)) begin
      nerr++; $display("FAIL zeros_result: got %b at cycle %0d need %b at 19", res, vcyc, exp_res(0));
    end
    iResReady = 1'b1;
    @(negedge iClk);
    iResReady = 1'b0;
  endtask

  task automatic test_alternating;
    logic [5:0] res;
    int vcyc, clr_c, load_c, en_first, en_last;
    op(2, res, vcyc, clr_c, load_c, en_first, en_last);
    nvec++;
    if (vcyc !== 19 || res !== exp_res(8)) begin
      nerr++; $display("FAIL alt_result: got %b at cycle %0d need %b at 19", res, vcyc, exp_res(8));
    end
    iResReady = 1'b1;
    @(negedge iClk);
    iResReady = 1'b0;
  endtask

  task automatic test_abort;
    logic [5:0] res;
    int vcyc, clr_c, load_c, en_first, en_last;
    int seen_valid;
    @(negedge iClk);
    iReqValid = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge iClk);
      iReqValid = 1'b0;
      iMult = 1'b1;
    end
    nvec++;
    if (oEn !== 1'b1 || oBusy !== 1'b1) begin
      nerr++; $display("FAIL abort_pre_run: got en=%b busy=%b need 1 1", oEn, oBusy);
    end
    iAbort = 1'b1;
    @(negedge iClk);
    iAbort = 1'b0;
    nvec++;
    if (oEn !== 1'b0 || oReqReady !== 1'b1 || oBusy !== 1'b0 || oClr !== 1'b0 || oLoadB !== 1'b0) begin
      nerr++;
      $display("FAIL abort_idle: got en=%b rdy=%b busy=%b clr=%b ld=%b need 0 1 0 0 0",
               oEn, oReqReady, oBusy, oClr, oLoadB);
    end
    seen_valid = 0;
    repeat (25) begin
      @(negedge iClk);
      if (oResValid) seen_valid++;
    end
    iMult = 1'b0;
    nvec++;
    if (seen_valid !== 0) begin
      nerr++; $display("FAIL abort_no_result: got %0d valid cycles need 0", seen_valid);
    end
    op(1, res, vcyc, clr_c, load_c, en_first, en_last);
    nvec++;
    if (vcyc !== 19 || res !== exp_res(16)) begin
      nerr++; $display("FAIL abort_recovery: got %b at cycle %0d need %b at 19", res, vcyc, exp_res(16));
    end
    iResReady = 1'b1;
    @(negedge iClk);
    iResReady = 1'b0;
  endtask

  task automatic test_backpressure;
    logic [5:0] res;
    int vcyc, clr_c, load_c, en_first, en_last;
    int bad;
    op(2, res, vcyc, clr_c, load_c, en_first, en_last);
    nvec++;
    if (vcyc !== 19 || res !== exp_res(8)) begin
      nerr++; $display("FAIL bp_first_result: got %b at cycle %0d need %b at 19", res, vcyc, exp_res(8));
    end
    iReqValid = 1'b1;
    bad = 0;
    repeat (3) begin
      @(negedge iClk);
      if (oResValid !== 1'b1 || oRes !== exp_res(8) || oReqReady !== 1'b0 || oClr !== 1'b0) bad++;
    end
    nvec++;
    if (bad !== 0) begin
      nerr++; $display("FAIL bp_hold: got %0d unstable cycles need 0", bad);
    end
    iResReady = 1'b1;
    @(negedge iClk);
    iResReady = 1'b0;
    nvec++;
    if (oResValid !== 1'b0 || oReqReady !== 1'b1 || oClr !== 1'b0) begin
      nerr++;
      $display("FAIL bp_release: got vld=%b rdy=%b clr=%b need 0 1 0", oResValid, oReqReady, oClr);
    end
    @(negedge iClk);
    iReqValid = 1'b0;
    nvec++;
    if (oClr !== 1'b1 || oReqReady !== 1'b0) begin
      nerr++; $display("FAIL bp_pending_accept: got clr=%b rdy=%b need 1 0", oClr, oReqReady);
    end
    iAbort = 1'b1;
    @(negedge iClk);
    iAbort = 1'b0;
    nvec++;
    if (oBusy !== 1'b0 || oLoadB !== 1'b0) begin
      nerr++; $display("FAIL abort_in_clr: got busy=%b ld=%b need 0 0", oBusy, oLoadB);
    end
  endtask

  task automatic test_reset_mid_run;
    logic [5:0] res;
    int vcyc, clr_c, load_c, en_first, en_last;
    @(negedge iClk);
    iReqValid = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge iClk);
      iReqValid = 1'b0;
      iMult = 1'b1;
    end
    iRst = 1'b1;
    #1;
    nvec++;
    if ({oReqReady, oClr, oLoadB, oEn, oBusy, oResValid} !== 6'b100000 || oRes !== 6'd0) begin
      nerr++;
      $display("FAIL midrun_reset: got rdy/clr/ld/en/busy/vld=%b res=%0d need 100000 res=0",
               {oReqReady, oClr, oLoadB, oEn, oBusy, oResValid}, oRes);
    end
    @(negedge iClk);
    iRst = 1'b0;
    iMult = 1'b0;
    op(1, res, vcyc, clr_c, load_c, en_first, en_last);
    nvec++;
    if (vcyc !== 19 || res !== exp_res(16)) begin
      nerr++; $display("FAIL midrun_recovery: got %b at cycle %0d need %b at 19", res, vcyc, exp_res(16));
    end
    iResReady = 1'b1;
    @(negedge iClk);
    iResReady = 1'b0;
  endtask

  initial begin
    test_reset;
    test_ones;
    test_zeros;
    test_alternating;
    test_abort;
    test_backpressure;
    test_reset_mid_run;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/umul_bi_ctrl.md
# umul_bi_ctrl

Sequencer for one bipolar unary multiplier lane (`uMUL_bi`) in the scaler SFFT datapath. It accepts a multiply request with a valid/ready handshake and then drives the lane's control pins in order:

- clears both Sobol generators,
- captures the B operand bit,
- enables the lane for exactly 2^BITWIDTH cycles.

While the lane runs, it counts the ones on the returned product stream and presents the count as a held result with a valid/ready handshake.

## Interface
Parameters:
- BITWIDTH, 8, Sobol RNG width; the run length is 2^BITWIDTH cycles.

Ports:
- iClk  in  1  clock; everything samples on the rising edge.
- iRst  in  1  reset, asynchronous, active-high.
- iReqValid  in  1  a multiply request is pending.
- oReqReady  out  1  controller can accept a request; high only in IDLE.
- iAbort  in  1  cancel the operation in flight; no result is produced.
- iMult  in  1  product bit from the lane (`oMult`).
- oClr  out  1  to the lane `iClr`; clears both Sobol RNGs.
- oLoadB  out  1  to the lane `loadB`; upstream presents `iB` this cycle.
- oEn  out  1  to the lane `iEn`.
- oBusy  out  1  high in every state except IDLE.
- oResValid  out  1  result is held on oRes.
- iResReady  in  1  consumer takes the result.
- oRes  out  BITWIDTH+2  result; encoding is set by the Configuration macro.

## Operation
- States and transitions:
  - IDLE → CLR when iReqValid && oReqReady.
  - CLR → LOAD after 1 cycle.
  - LOAD → RUN after 1 cycle.
  - RUN → DONE when the cycle counter equals 2^BITWIDTH−1.
  - DONE → IDLE when iResReady.
- Outputs by state:
  - CLR: oClr=1, oEn=0, oLoadB=0.
  - LOAD: oLoadB=1, oEn=1.
  - RUN: oEn=1, oLoadB=0, oClr=0.
  - DONE: oEn=0, oResValid=1.
- Cycle counter:
  - BITWIDTH bits, cleared in CLR, increments every RUN cycle.
  - The terminal value 2^BITWIDTH−1 triggers the exit from RUN.
  - The counter wraps to 0 on that exit and is never read outside RUN.
- Ones accumulator:
  - BITWIDTH+1 bits, cleared in CLR, adds iMult on every RUN cycle.
  - Range is 0..2^BITWIDTH. It cannot overflow, so no saturation is needed.
- oRes is registered on entry to DONE and held stable while oResValid=1.
- iAbort:
  - In CLR, LOAD or RUN: forces IDLE on the next edge. oEn, oClr and oLoadB go to 0 and no result is produced.
  - In IDLE: ignored. A simultaneous iReqValid is accepted normally.
  - In DONE: ignored. The result still completes its handshake.
- iReqValid outside IDLE is ignored; oReqReady=0 there.
- Reset (asynchronous, also mid-operation):
  - State returns to IDLE and both counters go to 0.
  - Output values during reset: oReqReady=1, oClr=0, oLoadB=0, oEn=0, oBusy=0, oResValid=0, oRes=0.
  - The lane is not cleared by reset. The next request's CLR cycle clears it.

## Timing
- Request accepted at edge 0:
  - CLR in cycle 1, LOAD in cycle 2.
  - RUN covers cycles 3 .. 2^BITWIDTH+2.
  - oResValid rises in cycle 2^BITWIDTH+3.
- Minimum request-to-request period is 2^BITWIDTH+4 cycles:
  - iResReady high in the first DONE cycle gives IDLE on the next cycle.
  - oReqReady is high in that IDLE cycle.
- iMult is sampled on the same edge as the matching oEn=1 RUN cycle, with zero added latency. The lane's product is combinational from its buffered B.
- The LOAD cycle's iMult is not counted, because the B buffer is not yet valid.
- Backpressure: DONE holds indefinitely with oRes stable until iResReady=1.

## Configuration
- UMUL_CTRL_BIPOLAR_OUT_EN
  - Defined: oRes is a two's-complement bipolar value equal to 2·ones − 2^BITWIDTH, range −2^BITWIDTH..+2^BITWIDTH, width BITWIDTH+2.
  - Undefined: oRes is the unsigned ones count, zero-extended to BITWIDTH+2.
- Control timing is identical in both builds.

## Test plan
All scenarios use BITWIDTH=4, so RUN lasts 16 cycles.
- iMult held 1, request at edge 0:
  - oClr in cycle 1, oLoadB in cycle 2, oEn high in cycles 2–18.
  - oResValid in cycle 19.
  - oRes=16, or +16 with the macro defined.
- iMult held 0: oRes=0, or −16 (6'b110000) with the macro defined.
- iMult alternating 1,0 starting at the first RUN cycle: oRes=8, or 0 with the macro defined.
- iAbort pulsed in the 5th RUN cycle:
  - Next cycle: IDLE, oEn=0, oReqReady=1.
  - oResValid never rises.
  - A new request then completes normally.
- iResReady held low for 3 DONE cycles:
  - oResValid and oRes stay stable.
  - oReqReady=0 and a pending iReqValid is not accepted until after the handshake.
- iRst asserted mid-RUN:
  - All outputs take their reset values immediately.
  - After release, a fresh request with iMult=1 yields 16. The accumulator and counter carry no residue.
